if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined MIPS core, directly upstream of the IF/ID pipeline register. It owns the program counter and a word-addressed instruction memory with a load port. Each cycle it presents one instruction and its PC+1 to IF/ID. It honours stall, jump and branch-taken redirects from later stages, and stops on a halt word.

---
 rtl/if_fetch_stage.sv | 64 ++++++
 tb/tb_if_fetch_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, loadable instruction memory and IF/ID feed with stall, redirect and halt handling.
module if_fetch_stage #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [15:0]       load_data,
  input  logic              stall,
  input  logic              jump,
  input  logic [15:0]       jump_target,
  input  logic              branch,
  input  logic [15:0]       branch_target,
  output logic [15:0]       ins_out,
  output logic [15:0]       pc_out,
  output logic [15:0]       pc_cur,
  output logic              running,
  output logic              halted,
  output logic [15:0]       icount
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nxt;
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [15:0] word, pc_nxt;
  logic is_halt, redirect, issue;
  assign word     = mem[pc_cur[ADDR_W-1:0]];
  assign is_halt  = word == HALT_WORD;
  assign redirect = branch || jump;
  // a redirect retires the current word unless it is the halt word, which was on the wrong path
  assign issue    = running && !is_halt && (redirect || !stall);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = (start && state != RUN) ? RUN :
                (state == RUN && !redirect && !stall && is_halt) ? HALT : state;
  always_comb begin
    running = state == RUN;
    halted  = state == HALT;
    ins_out = (running && !is_halt) ? word : 16'h0000;
    pc_out  = pc_cur + 16'd1;
    pc_nxt  = branch ? branch_target :
              jump ? jump_target :
              (stall || is_halt) ? pc_cur : pc_cur + 16'd1;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pc_cur <= RESET_PC;
      icount <= 16'h0000;
    end else begin
      if (start && !running)
        pc_cur <= RESET_PC;
      else if (running)
        pc_cur <= pc_nxt;
      if (issue && icount != 16'hFFFF)
        icount <= icount + 16'd1;
    end
  always_ff @(posedge clk)
    if (!rst && state == IDLE && load_en)
      mem[load_addr] <= load_data;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed test-plan steps plus a randomized phase against a cycle-level reference model.
module tb_if_fetch_stage;
  logic        clk = 0, rst, start, load_en, stall, jump, branch;
  logic [7:0]  load_addr;
  logic [15:0] load_data, jump_target, branch_target;
  logic [15:0] ins_out, pc_out, pc_cur, icount;
  logic        running, halted;
  int checks = 0, errors = 0;
  logic [15:0] m_mem [0:255];
  logic [15:0] m_pc, m_cnt;
  logic        m_run, m_halt;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_target(branch_target), .ins_out(ins_out), .pc_out(pc_out),
    .pc_cur(pc_cur), .running(running), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    rst = 0; start = 0; load_en = 0; load_addr = 0; load_data = 0;
    stall = 0; jump = 0; jump_target = 0; branch = 0; branch_target = 0;
  endtask

  // advance one edge with the current inputs, update the model, compare every output
  task automatic tick();
    logic [15:0] w, e_ins;
    w = m_mem[m_pc[7:0]];
    if (rst) begin
      m_pc = 16'h0000; m_cnt = 0; m_run = 0; m_halt = 0;
    end else if (m_run) begin
      if (w != 16'hFFFF && (branch || jump || !stall) && m_cnt != 16'hFFFF) m_cnt++;
      if (branch) m_pc = branch_target;
      else if (jump) m_pc = jump_target;
      else if (!stall) begin
        if (w == 16'hFFFF) begin m_run = 0; m_halt = 1; end
        else m_pc = m_pc + 16'd1;
      end
    end else begin
      if (!m_halt && load_en) m_mem[load_addr] = load_data;
      if (start) begin m_pc = 16'h0000; m_run = 1; m_halt = 0; end
    end
    @(posedge clk);
    #1;
    w = m_mem[m_pc[7:0]];
    e_ins = (m_run && w != 16'hFFFF) ? w : 16'h0000;
    chk("m_ins_out", ins_out, e_ins);
    chk("m_pc_out", pc_out, m_pc + 16'd1);
    chk("m_pc_cur", pc_cur, m_pc);
    chk("m_running", {15'd0, running}, {15'd0, m_run});
    chk("m_halted", {15'd0, halted}, {15'd0, m_halt});
    chk("m_icount", icount, m_cnt);
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1; tick();
    chk("rst_pc", pc_cur, 16'h0000);
    chk("rst_icount", icount, 16'h0000);
    chk("rst_ins", ins_out, 16'h0000);
    for (int i = 0; i < 256; i++) begin
      load_en = 1; load_addr = 8'(i);
      case (i)
        0: load_data = 16'h1111;
        1: load_data = 16'h2222;
        2: load_data = 16'h3333;
        3: load_data = 16'hFFFF;
        255: load_data = 16'hABCD;
        default: load_data = 16'($urandom_range(0, 16'hFFFE));
      endcase
      tick();
    end
    start = 1; tick();
    chk("run_ins0", ins_out, 16'h1111);
    tick();
    chk("run_ins1", ins_out, 16'h2222);
    chk("run_pc1", pc_cur, 16'h0001);
    for (int i = 0; i < 2; i++) begin
      stall = 1; tick();
      chk("stall_ins", ins_out, 16'h2222);
      chk("stall_pc_out", pc_out, 16'h0002);
      chk("stall_icount", icount, 16'h0001);
    end
    tick();
    chk("run_ins2", ins_out, 16'h3333);
    tick();
    chk("halt_word_ins", ins_out, 16'h0000);
    chk("halt_word_running", {15'd0, running}, 16'h0001);
    tick();
    chk("halted", {15'd0, halted}, 16'h0001);
    chk("halt_pc", pc_cur, 16'h0003);
    chk("halt_icount", icount, 16'h0003);
    start = 1; tick();
    chk("restart_ins", ins_out, 16'h1111);
    jump = 1; jump_target = 16'h0003; tick();
    chk("at_halt_ins", ins_out, 16'h0000);
    jump = 1; jump_target = 16'h0005; tick();
    chk("redir_halt_pc", pc_cur, 16'h0005);
    chk("redir_halt_halted", {15'd0, halted}, 16'h0000);
    chk("redir_halt_running", {15'd0, running}, 16'h0001);
    jump = 1; jump_target = 16'h0010; branch = 1; branch_target = 16'h0020; stall = 1; tick();
    chk("both_pc", pc_cur, 16'h0020);
    chk("both_pc_out", pc_out, 16'h0021);
    jump = 1; jump_target = 16'hFFFF; tick();
    chk("wrap_ins", ins_out, 16'hABCD);
    chk("wrap_pc_out", pc_out, 16'h0000);
    tick();
    chk("wrap_pc", pc_cur, 16'h0000);
    rst = 1; tick();
    chk("mid_rst_running", {15'd0, running}, 16'h0000);
    chk("mid_rst_ins", ins_out, 16'h0000);
    chk("mid_rst_pc", pc_cur, 16'h0000);
    chk("mid_rst_icount", icount, 16'h0000);
    start = 1; tick();
    chk("retain_ins", ins_out, 16'h1111);
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 15) == 0;
      load_en = $urandom_range(0, 1) == 1;
      load_addr = 8'($urandom);
      load_data = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      stall = $urandom_range(0, 3) == 0;
      jump = $urandom_range(0, 7) == 0;
      jump_target = 16'($urandom);
      branch = $urandom_range(0, 9) == 0;
      branch_target = 16'($urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
